int_sync_crossing_sink_n: RTL and testbench
===========================================

# int_sync_crossing_sink_n

Parametrised interrupt-crossing sink: receives N interrupt lines from a source clock domain, synchronises them into the local `clock` domain with a configurable number of flop stages, and presents them as level or edge-latched interrupts. Edge channels carry a sticky pending bit with a per-channel clear. The block sits between a tile/peripheral interrupt source and the PLIC/CLINT gateway inputs. It replaces the fixed two-wire passthrough sink used in synchronous crossings.

## Interface
- `N`, 2: number of interrupt channels (1..64).
- `SYNC_STAGES`, 3: synchroniser depth. 0 means a synchronous crossing with no flops; 1 means a rational crossing; 2 or more means an asynchronous crossing.
- `EDGE_MASK`, 0: N-bit mask. Bit i = 1 makes channel i edge-latched; bit i = 0 makes it level.

- `clock`  in  1  sole clock; all state is on its rising edge.
- `reset_n`  in  1  asynchronous assert, active-low; synchronous release is the integrator's responsibility.
- `auto_in_sync`  in  N  raw interrupt lines from the source domain.
- `enable`  in  N  per-channel output gate; synchronous to `clock`.
- `clear`  in  N  per-channel pending-clear pulse; edge channels only.
- `auto_out`  out  N  delivered interrupts.
- `pending`  out  N  raw pending state, readable even when the channel is disabled. Always 0 on level channels.
- `irq_any`  out  1  OR-reduction of `auto_out`.

## Operation
- Synchroniser, per channel: an S-flop shift chain `s[0..S-1]`, with `sync_i = s[S-1]`. When S = 0, `sync_i = auto_in_sync[i]`, purely combinational.
- Level channel (`EDGE_MASK[i]=0`): `auto_out[i] = sync_i & enable[i]`. No further state.
- Edge channel (`EDGE_MASK[i]=1`):
  - `prev_i` registers `sync_i` every cycle.
  - `rise_i = sync_i & ~prev_i`.
  - Next pending value: `pend_i_next = rise_i | (pend_i & ~clear[i])`. A rise and a clear in the same cycle leave pending set, because set wins.
  - `auto_out[i] = pend_i & enable[i]`.
  - Falling edges and a held-high level do not re-set pending.
- Masking: `enable` gates only the output. Edges arriving while disabled still set pending and are delivered once enabled.
- `clear` on a level channel is ignored. `clear` on a channel that is not pending has no effect.
- Reset: all `s[]`, `prev_i` and `pend_i` go to 0 immediately on `reset_n` low, so `auto_out`, `pending` and `irq_any` are 0.
  - A line already high at reset release produces one rise, so edge channels become pending at the first clock after release plus the synchroniser latency.
  - Reset asserted mid-operation discards all pending state.
- Width rules: every vector is exactly N bits. `EDGE_MASK` bits at index N and above are ignored.

## Timing
- Level path latency from an `auto_in_sync` change to `auto_out` is S clock edges, or 0 (combinational) when S = 0.
- Edge path latency from a rise at the input to `pending`/`auto_out` high is S+1 edges, since the synchroniser is followed by the pending flop.
- Clear latency: `clear[i]` sampled high at edge k gives `pending[i]` = 0 after edge k, unless a rise is also present at edge k.
- `enable` and `irq_any` are combinational relative to the register outputs. There is no added latency.
- Input pulse width:
  - S = 0: pulses must be at least 1 `clock` cycle wide.
  - S ≥ 1: pulses must be at least 2 destination cycles wide to be guaranteed captured.
  - Shorter pulses may be lost; this is permitted and not an error.

## Structure
- Package `int_sync_pkg` holds the channel-width limit `INT_SYNC_MAX_N = 64` and the crossing-kind constants `INT_SYNC_SYNC = 0`, `INT_SYNC_RATIONAL = 1` and `INT_SYNC_ASYNC_MIN = 2`, all mapped to `SYNC_STAGES`.
- Sub-module `int_sync_synchronizer`: a single-bit, `SYNC_STAGES`-deep flop chain with async active-low reset and a generate bypass for depth 0. The top level instantiates it N times.
- Edge and pending logic stays in the top level as a generate loop over `EDGE_MASK`.

## Test plan
- Level, S=3, N=2, `enable`=2'b11: raise `auto_in_sync[0]` at cycle 10. Required: `auto_out[0]`=1 from cycle 13 and `irq_any`=1. Drop the input at cycle 20. Required: `auto_out[0]`=0 at cycle 23.
- Edge, S=2, `EDGE_MASK`=2'b10: a 3-cycle pulse on ch1 at cycle 5 gives `pending[1]`=1 at cycle 8 and holding. Pulse `clear[1]` at cycle 12. Required: `pending[1]`=0 from cycle 13.
- Simultaneous rise and clear on an edge channel with S=0: a rise and `clear` in the same cycle leave `pending`=1. A lone `clear` the next cycle gives 0.
- Masked capture: `enable[1]`=0 while an edge arrives. Required: `pending[1]`=1 and `auto_out[1]`=0. Set `enable[1]`=1. Required: `auto_out[1]`=1 in the same cycle.
- Reset mid-operation: with `pending`=2'b10, assert `reset_n`=0 asynchronously. Required: all outputs 0 immediately. Release `reset_n` with ch1 input held high and S=2. Required: `pending[1]`=1 exactly 3 edges after release.
- Bypass S=0, level, N=64 with a walking-one on `auto_in_sync`. Required: `auto_out` equals the input combinationally on every bit.

Source files
------------

// File: rtl/int_sync_pkg.sv
// ---------------------------------------------------------------------------
// int_sync_pkg
// Shared constants for the interrupt-crossing sink and its synchroniser.
//   INT_SYNC_MAX_N      : widest supported interrupt vector
//   INT_SYNC_SYNC       : SYNC_STAGES value for a synchronous crossing (no flops)
//   INT_SYNC_RATIONAL   : SYNC_STAGES value for a rational crossing (one flop)
//   INT_SYNC_ASYNC_MIN  : smallest SYNC_STAGES value treated as asynchronous
// int_sync_kind() maps a stage count onto the crossing kind.
// ---------------------------------------------------------------------------
package int_sync_pkg;

    localparam int INT_SYNC_MAX_N     = 64;
    localparam int INT_SYNC_SYNC      = 0;
    localparam int INT_SYNC_RATIONAL  = 1;
    localparam int INT_SYNC_ASYNC_MIN = 2;

    typedef enum logic [1:0] {
        XING_SYNC     = 2'd0,
        XING_RATIONAL = 2'd1,
        XING_ASYNC    = 2'd2
    } int_sync_kind_e;

    function automatic int_sync_kind_e int_sync_kind(input int stages);
        if (stages >= INT_SYNC_ASYNC_MIN) begin
            return XING_ASYNC;
        end else if (stages == INT_SYNC_RATIONAL) begin
            return XING_RATIONAL;
        end else begin
            return XING_SYNC;
        end
    endfunction

endpackage

// File: rtl/int_sync_synchronizer.sv
// ---------------------------------------------------------------------------
// int_sync_synchronizer
// Single-bit flop chain bringing one interrupt line into the clock domain.
// A depth of zero collapses to a wire (synchronous crossing).
// Ports:
//   clock   : destination clock, rising edge
//   reset_n : asynchronous active-low reset, clears every stage
//   d       : raw line from the source domain
//   q       : synchronised line (last stage, or d when depth is zero)
// ---------------------------------------------------------------------------
module int_sync_synchronizer
    import int_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 3
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    localparam int_sync_kind_e KIND = int_sync_kind(SYNC_STAGES);

    generate
        if (KIND == XING_SYNC) begin : g_bypass
            // Clock and reset have nothing to drive in the bypass case.
            logic unused_clk_rst;
            assign unused_clk_rst = clock ^ reset_n;
            assign q = d;
        end else begin : g_chain
            for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
                logic stage_d;
                logic stage_reg;

                if (gi == 0) begin : g_first
                    assign stage_d = d;
                end else begin : g_next
                    assign stage_d = g_stage[gi-1].stage_reg;
                end

                always_ff @(posedge clock or negedge reset_n) begin
                    if (!reset_n) begin
                        stage_reg <= 1'b0;
                    end else begin
                        stage_reg <= stage_d;
                    end
                end
            end

            assign q = g_stage[SYNC_STAGES-1].stage_reg;
        end
    endgenerate

endmodule

// File: rtl/int_sync_crossing_sink_n.sv
// ---------------------------------------------------------------------------
// int_sync_crossing_sink_n
// N-channel interrupt-crossing sink. Each line is synchronised into the local
// clock domain, then delivered either as a level (gated by enable) or as a
// sticky edge-latched pending bit with a per-channel clear.
// Ports:
//   clock        : sole clock, rising edge
//   reset_n      : asynchronous assert, active-low
//   auto_in_sync : N raw interrupt lines from the source domain
//   enable       : N per-channel output gates (combinational)
//   clear        : N per-channel pending clears (edge channels only)
//   auto_out     : N delivered interrupts
//   pending      : N raw pending bits (always 0 on level channels)
//   irq_any      : OR of auto_out
// Parameters:
//   N            : channel count, 1..INT_SYNC_MAX_N
//   SYNC_STAGES  : synchroniser depth (0 = synchronous bypass)
//   EDGE_MASK    : bit i set makes channel i edge-latched; bits >= N ignored
// ---------------------------------------------------------------------------
module int_sync_crossing_sink_n
    import int_sync_pkg::*;
#(
    parameter int                          N           = 2,
    parameter int                          SYNC_STAGES = 3,
    parameter logic [INT_SYNC_MAX_N-1:0]   EDGE_MASK   = '0
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] auto_in_sync,
    input  logic [N-1:0] enable,
    input  logic [N-1:0] clear,
    output logic [N-1:0] auto_out,
    output logic [N-1:0] pending,
    output logic         irq_any
);

    logic [N-1:0] sync_vec;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            int_sync_synchronizer #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .clock   (clock),
                .reset_n (reset_n),
                .d       (auto_in_sync[gi]),
                .q       (sync_vec[gi])
            );

            if (EDGE_MASK[gi]) begin : g_edge
                logic prev_reg;
                logic pend_reg;
                logic rise;
                logic pend_next;

                assign rise      = sync_vec[gi] & ~prev_reg;
                // A new rise beats a simultaneous clear.
                assign pend_next = rise | (pend_reg & ~clear[gi]);

                always_ff @(posedge clock or negedge reset_n) begin
                    if (!reset_n) begin
                        prev_reg <= 1'b0;
                        pend_reg <= 1'b0;
                    end else begin
                        prev_reg <= sync_vec[gi];
                        pend_reg <= pend_next;
                    end
                end

                assign pending[gi]  = pend_reg;
                assign auto_out[gi] = pend_reg & enable[gi];
            end else begin : g_level
                // Level channels have no pending state to clear.
                logic unused_clear;
                assign unused_clear = clear[gi];

                assign pending[gi]  = 1'b0;
                assign auto_out[gi] = sync_vec[gi] & enable[gi];
            end
        end
    endgenerate

    assign irq_any = |auto_out;

endmodule

// File: tb/tb_int_sync_crossing_sink_n.sv
// ---------------------------------------------------------------------------
// tb_int_sync_crossing_sink_n
// Directed scenarios on four configurations, followed by a randomized phase
// checked against a delay-line / sticky-bit reference model.
//   A: N=2,  S=3, all level
//   B: N=2,  S=2, ch1 edge, ch0 level
//   C: N=2,  S=0, both edge
//   D: N=64, S=0, all level
// ---------------------------------------------------------------------------
module tb_int_sync_crossing_sink_n;

    logic clock;
    logic reset_n;

    logic [1:0]  a_in, a_en, a_clr, a_out, a_pend;
    logic        a_any;
    logic [1:0]  b_in, b_en, b_clr, b_out, b_pend;
    logic        b_any;
    logic [1:0]  c_in, c_en, c_clr, c_out, c_pend;
    logic        c_any;
    logic [63:0] d_in, d_en, d_clr, d_out, d_pend;
    logic        d_any;

    int n_checks = 0;
    int n_errors = 0;

    int_sync_crossing_sink_n #(.N(2), .SYNC_STAGES(3), .EDGE_MASK(64'h0)) u_a (
        .clock(clock), .reset_n(reset_n), .auto_in_sync(a_in), .enable(a_en),
        .clear(a_clr), .auto_out(a_out), .pending(a_pend), .irq_any(a_any));

    int_sync_crossing_sink_n #(.N(2), .SYNC_STAGES(2), .EDGE_MASK(64'h2)) u_b (
        .clock(clock), .reset_n(reset_n), .auto_in_sync(b_in), .enable(b_en),
        .clear(b_clr), .auto_out(b_out), .pending(b_pend), .irq_any(b_any));

    int_sync_crossing_sink_n #(.N(2), .SYNC_STAGES(0), .EDGE_MASK(64'h3)) u_c (
        .clock(clock), .reset_n(reset_n), .auto_in_sync(c_in), .enable(c_en),
        .clear(c_clr), .auto_out(c_out), .pending(c_pend), .irq_any(c_any));

    int_sync_crossing_sink_n #(.N(64), .SYNC_STAGES(0), .EDGE_MASK(64'h0)) u_d (
        .clock(clock), .reset_n(reset_n), .auto_in_sync(d_in), .enable(d_en),
        .clear(d_clr), .auto_out(d_out), .pending(d_pend), .irq_any(d_any));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, {61'd0, a_any, a_out}, 64'd0);
        check({tag, "_b"}, {59'd0, b_any, b_pend, b_out}, 64'd0);
        check({tag, "_c"}, {59'd0, c_any, c_pend, c_out}, 64'd0);
        check({tag, "_dout"}, d_out, 64'd0);
        check({tag, "_dany"}, {63'd0, d_any}, 64'd0);
    endtask

    // Reference model state: input history (index 0 = value sampled at the
    // most recent edge) and the sticky pending bits.
    logic [1:0] hist_b[$];
    logic [1:0] hist_c[$];
    logic       pend_b1;
    logic [1:0] pend_c;

    initial begin
        logic [1:0] rise_c;
        logic       rise_b1;
        logic [63:0] walk;

        reset_n = 1'b0;
        a_in = '0; a_en = '0; a_clr = '0;
        b_in = '0; b_en = '0; b_clr = '0;
        c_in = '0; c_en = '0; c_clr = '0;
        d_in = '0; d_en = '0; d_clr = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        a_en = 2'b11; b_en = 2'b11; c_en = 2'b11; d_en = '1;
        a_in = 2'b11; c_in = 2'b11; d_in = '1;
        #1;
        // While held in reset nothing propagates except the S=0 level path.
        check("reset_a", {61'd0, a_any, a_out}, 64'd0);
        check("reset_b", {59'd0, b_any, b_pend, b_out}, 64'd0);
        check("reset_c", {59'd0, c_any, c_pend, c_out}, 64'd0);
        a_in = '0; c_in = '0; d_in = '0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // ---------------- A: level, S=3 ----------------
        a_in[0] = 1'b1;
        tick(); tick();
        check("lvl_rise_early", {61'd0, a_any, a_out}, 64'd0);
        tick();
        check("lvl_rise_out", {62'd0, a_out}, 64'd1);
        check("lvl_rise_any", {63'd0, a_any}, 64'd1);
        repeat (4) tick();
        check("lvl_hold", {62'd0, a_out}, 64'd1);
        a_in[0] = 1'b0;
        tick(); tick();
        check("lvl_fall_early", {62'd0, a_out}, 64'd1);
        tick();
        check("lvl_fall_out", {61'd0, a_any, a_out}, 64'd0);
        a_en = 2'b10; a_in = 2'b01;
        repeat (3) tick();
        check("lvl_gated", {61'd0, a_any, a_out}, 64'd0);
        a_in = 2'b00;

        // ---------------- B: edge ch1, S=2, 3-cycle pulse ----------------
        b_in[1] = 1'b1;
        tick(); tick();
        check("edge_early", {62'd0, b_pend}, 64'd0);
        tick();
        check("edge_pend", {62'd0, b_pend}, 64'd2);
        check("edge_out", {61'd0, b_any, b_out}, 64'h6);
        b_in[1] = 1'b0;
        repeat (4) tick();
        check("edge_hold", {62'd0, b_pend}, 64'd2);
        b_clr[1] = 1'b1;
        tick();
        b_clr[1] = 1'b0;
        check("edge_clear", {61'd0, b_any, b_pend}, 64'd0);
        b_clr[1] = 1'b1;
        tick();
        b_clr[1] = 1'b0;
        check("edge_clear_idle", {62'd0, b_pend}, 64'd0);

        // ---------------- C: S=0 rise and clear together ----------------
        c_in[0] = 1'b1; c_clr[0] = 1'b1;
        tick();
        check("setwins_pend", {62'd0, c_pend}, 64'd1);
        check("setwins_out", {62'd0, c_out}, 64'd1);
        tick();
        check("held_high_clear", {62'd0, c_pend}, 64'd0);
        c_clr = '0;
        repeat (2) tick();
        check("held_high_norearm", {62'd0, c_pend}, 64'd0);
        c_in = '0;
        tick();
        check("fall_noset", {62'd0, c_pend}, 64'd0);
        c_clr[1] = 1'b1; c_in[0] = 1'b1;
        tick();
        check("clear_other_chan", {62'd0, c_pend}, 64'd1);
        c_clr = 2'b01; c_in = '0;
        tick();
        c_clr = '0;

        // ---------------- B: masked capture ----------------
        b_en = 2'b01;
        b_in[1] = 1'b1;
        repeat (3) tick();
        check("mask_pend", {62'd0, b_pend}, 64'd2);
        check("mask_out", {61'd0, b_any, b_out}, 64'd0);
        b_en = 2'b11;
        #1;
        check("unmask_out", {62'd0, b_out}, 64'd2);
        check("unmask_any", {63'd0, b_any}, 64'd1);

        // ---------------- D: S=0 bypass walking one ----------------
        d_en = '1;
        for (int i = 0; i < 64; i++) begin
            walk = 64'd1 << i;
            d_in = walk;
            #1;
            check($sformatf("walk_out_%0d", i), d_out, walk);
            check($sformatf("walk_any_%0d", i), {63'd0, d_any}, 64'd1);
        end
        d_in = 64'hA5A5_5A5A_F00F_0FF0;
        d_en = 64'h0123_4567_89AB_CDEF;
        #1;
        check("bypass_gate", d_out, 64'h0121_4042_800B_0DE0);
        check("bypass_pend", d_pend, 64'd0);
        d_in = '0;

        // ---------------- reset mid-operation ----------------
        tick();
        c_in = 2'b01; a_in = 2'b01; a_en = 2'b11;
        repeat (4) tick();
        check("premid_b", {62'd0, b_pend}, 64'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clock);
        reset_n = 1'b1;
        tick(); tick();
        check("release_early", {62'd0, b_pend}, 64'd0);
        tick();
        check("release_pend", {62'd0, b_pend}, 64'd2);

        // ---------------- randomized phase ----------------
        @(negedge clock);
        reset_n = 1'b0;
        a_in = '0; b_in = '0; b_clr = '0; c_in = '0; c_clr = '0;
        tick(); tick();
        @(negedge clock);
        reset_n = 1'b1;
        hist_b = '{2'b00, 2'b00, 2'b00, 2'b00};
        hist_c = '{2'b00, 2'b00};
        pend_b1 = 1'b0;
        pend_c  = 2'b00;
        for (int cyc = 0; cyc < 400; cyc++) begin
            b_in  = 2'($urandom);
            b_en  = 2'($urandom);
            b_clr = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            c_in  = 2'($urandom);
            c_en  = 2'($urandom);
            c_clr = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            tick();
            hist_b.push_front(b_in);
            void'(hist_b.pop_back());
            hist_c.push_front(c_in);
            void'(hist_c.pop_back());
            // S=2: the edge seen at this clock is between the inputs sampled
            // two and three edges ago.
            rise_b1 = hist_b[2][1] & ~hist_b[3][1];
            pend_b1 = rise_b1 | (pend_b1 & ~b_clr[1]);
            rise_c  = hist_c[0] & ~hist_c[1];
            pend_c  = rise_c | (pend_c & ~c_clr);
            check($sformatf("rnd_b_pend_%0d", cyc), {62'd0, b_pend}, {62'd0, pend_b1, 1'b0});
            check($sformatf("rnd_b_out_%0d", cyc), {61'd0, b_any, b_out},
                  {61'd0, (pend_b1 & b_en[1]) | (hist_b[1][0] & b_en[0]),
                   pend_b1 & b_en[1], hist_b[1][0] & b_en[0]});
            check($sformatf("rnd_c_pend_%0d", cyc), {62'd0, c_pend}, {62'd0, pend_c});
            check($sformatf("rnd_c_out_%0d", cyc), {61'd0, c_any, c_out},
                  {61'd0, |(pend_c & c_en), pend_c & c_en});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
